// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   lsuOp_t    - 3-bit operation codes carried on the Op port
//   lsuState_t - LSU state machine states
//   BYTE_MASK / HALF_MASK - lane masks positioned at lane 0
//   isStore / isMisaligned - request classification helpers
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SB  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } lsuOp_t;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} lsuState_t;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    function automatic logic isStore(input lsuOp_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic isHalf(input lsuOp_t op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic isMisaligned(input lsuOp_t op, input logic [1:0] offset);
        return (isHalf(op) && offset[0]) || ((op == OP_LW || op == OP_SW) && offset != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane extract/extend for loads and lane merge for sub-word stores.
//   op         in  operation of the request in flight
//   byteOffset in  ByteAddr[1:0] of the request
//   memWord    in  word read from DataMemory
//   storeData  in  store operand (low byte/half used)
//   loadValue  out extended load result (0 for non-load ops)
//   mergedWord out memWord with the store lane replaced (SB/SH)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsuOp_t      op,
    input  logic [1:0]  byteOffset,
    input  logic [31:0] memWord,
    input  logic [31:0] storeData,
    output logic [31:0] loadValue,
    output logic [31:0] mergedWord
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] laneMask;

    always_comb begin
        // Halfword accesses only use ByteAddr[1]; a misaligned one never reaches here.
        shamt      = isHalf(op) ? {byteOffset[1], 4'b0000} : {byteOffset, 3'b000};
        shifted    = memWord >> shamt;
        laneMask   = (op == OP_SH ? HALF_MASK : BYTE_MASK) << shamt;
        mergedWord = (memWord & ~laneMask) | ((storeData << shamt) & laneMask);
        loadValue  = op == OP_LB  ? {{24{shifted[7]}}, shifted[7:0]} :
                     op == OP_LBU ? {24'b0, shifted[7:0]} :
                     op == OP_LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                     op == OP_LHU ? {16'b0, shifted[15:0]} :
                     op == OP_LW  ? memWord : 32'b0;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding memory-access stage driving DataMemory.
//   Clk, Reset_n      clock and asynchronous active-low reset
//   Req/Ready         request handshake; Op, ByteAddr, StoreData latched on acceptance
//   LoadData          extended load result, held until the next load completes
//   Done              one-cycle completion pulse; Misaligned/OutOfRange valid with it
//   MemAddress, MemWriteData, MemRead, MemWrite, MemReadData  DataMemory interface
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req,
    output logic        Ready,
    input  logic [2:0]  Op,
    input  logic [31:0] ByteAddr,
    input  logic [31:0] StoreData,
    output logic [31:0] LoadData,
    output logic        Done,
    output logic        Misaligned,
    output logic        OutOfRange,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemReadData
);

    lsuState_t   state;
    lsuOp_t      opReg;
    logic [31:0] addrReg;
    logic [31:0] storeReg;
    logic [31:0] mergeBuf;
    logic [31:0] loadReg;
    logic        misReg;
    logic        oorReg;

    lsuOp_t      opIn;
    logic        misIn;
    logic        oorIn;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;

    assign opIn  = lsuOp_t'(Op);
    assign misIn = isMisaligned(opIn, ByteAddr[1:0]);
    assign oorIn = ByteAddr[31:2] >= 30'(MEM_WORDS);

    lsu_lane_align uAlign (
        .op        (opReg),
        .byteOffset(addrReg[1:0]),
        .memWord   (MemReadData),
        .storeData (storeReg),
        .loadValue (loadValue),
        .mergedWord(mergedWord)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            opReg    <= OP_LB;
            addrReg  <= '0;
            storeReg <= '0;
            mergeBuf <= '0;
            loadReg  <= '0;
            misReg   <= 1'b0;
            oorReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Req) begin
                    opReg    <= opIn;
                    addrReg  <= ByteAddr;
                    storeReg <= StoreData;
                    misReg   <= misIn;
                    oorReg   <= oorIn;
                    if (misIn || oorIn) begin
                        state <= DONE;
                        if (!isStore(opIn)) loadReg <= '0;
                    end else begin
                        state <= opIn == OP_SW ? WR : RD;
                    end
                end
                RD: begin
                    if (isStore(opReg)) begin
                        mergeBuf <= mergedWord;
                        state    <= WR;
                    end else begin
                        loadReg <= loadValue;
                        state   <= DONE;
                    end
                end
                WR:      state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register so reset drops MemWrite at once.
    assign Ready        = state == IDLE;
    assign Done         = state == DONE;
    assign Misaligned   = Done & misReg;
    assign OutOfRange   = Done & oorReg;
    assign MemRead      = state == RD;
    assign MemWrite     = state == WR;
    assign MemAddress   = (MemRead || MemWrite) ? {2'b00, addrReg[31:2]} : '0;
    assign MemWriteData = MemWrite ? (opReg == OP_SW ? storeReg : mergeBuf) : '0;
    assign LoadData     = loadReg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a DataMemory model.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req = 1'b0;
    logic        Ready;
    logic [2:0]  Op = 3'b000;
    logic [31:0] ByteAddr = '0;
    logic [31:0] StoreData = '0;
    logic [31:0] LoadData;
    logic        Done;
    logic        Misaligned;
    logic        OutOfRange;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData;

    logic [31:0] mem [128];

    int passCnt = 0;
    int totalCnt = 0;
    int lat, reads, writes, both, readyDuring;
    logic [31:0] rdAddr, wrData;
    logic mis, oor;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SB = 3'b011;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SH = 3'b110, SW = 3'b111;

    load_store_unit #(.MEM_WORDS(128)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Req         (Req),
        .Ready       (Ready),
        .Op          (Op),
        .ByteAddr    (ByteAddr),
        .StoreData   (StoreData),
        .LoadData    (LoadData),
        .Done        (Done),
        .Misaligned  (Misaligned),
        .OutOfRange  (OutOfRange),
        .MemAddress  (MemAddress),
        .MemWriteData(MemWriteData),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemReadData (MemReadData)
    );

    always #5 Clk = ~Clk;

    assign MemReadData = (MemRead && MemAddress < 32'd128) ? mem[MemAddress[6:0]] : 32'h0;

    always @(posedge Clk)
        if (MemWrite && MemAddress < 32'd128) mem[MemAddress[6:0]] <= MemWriteData;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic doOp(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data, input bit hold);
        int n = 0;
        @(negedge Clk);
        while (!Ready && n < 10) begin
            @(negedge Clk);
            n++;
        end
        Op = op;
        ByteAddr = addr;
        StoreData = data;
        Req = 1'b1;
        @(posedge Clk);
        #1 if (!hold) Req = 1'b0;
        lat = 99; reads = 0; writes = 0; both = 0; readyDuring = 0;
        mis = 1'b0; oor = 1'b0; rdAddr = '0; wrData = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (MemRead) begin reads++; rdAddr = MemAddress; end
            if (MemWrite) begin writes++; wrData = MemWriteData; end
            if (MemRead && MemWrite) both++;
            if (Done) begin
                lat = c;
                mis = Misaligned;
                oor = OutOfRange;
                break;
            end
            if (Ready) readyDuring++;
        end
        Req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]   = 32'hCAFE_F00D;
        mem[127] = 32'hDAD5_B00B;
        repeat (2) @(negedge Clk);
        check("rst_ready", {31'b0, Ready}, 32'd1);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_memrd", {31'b0, MemRead}, 32'd0);
        check("rst_memwr", {31'b0, MemWrite}, 32'd0);
        check("rst_loaddata", LoadData, 32'h0);
        Reset_n = 1'b1;

        doOp(LW, 32'h1FC, 32'h0, 1'b0);
        check("lw_data", LoadData, 32'hDAD5_B00B);
        check("lw_lat", lat, 2);
        check("lw_reads", reads, 1);
        check("lw_addr", rdAddr, 32'd127);
        check("lw_writes", writes, 0);
        @(negedge Clk);
        check("done_pulse", {31'b0, Done}, 32'd0);
        check("ready_back", {31'b0, Ready}, 32'd1);

        doOp(LB, 32'h1FD, 32'h0, 1'b0);
        check("lb_data", LoadData, 32'hFFFF_FFB0);
        doOp(LBU, 32'h1FD, 32'h0, 1'b0);
        check("lbu_data", LoadData, 32'h0000_00B0);
        doOp(LH, 32'h1FE, 32'h0, 1'b0);
        check("lh_data", LoadData, 32'hFFFF_DAD5);
        check("lh_lat", lat, 2);
        doOp(LHU, 32'h1FE, 32'h0, 1'b0);
        check("lhu_data", LoadData, 32'h0000_DAD5);

        doOp(SB, 32'h1FC, 32'h0000_0011, 1'b0);
        check("sb_lat", lat, 3);
        check("sb_reads", reads, 1);
        check("sb_writes", writes, 1);
        check("sb_wdata", wrData, 32'hDAD5_B011);
        check("sb_overlap", both, 0);
        check("sb_loaddata_held", LoadData, 32'h0000_DAD5);
        doOp(LW, 32'h1FC, 32'h0, 1'b0);
        check("sb_readback", LoadData, 32'hDAD5_B011);

        doOp(SH, 32'h1FF, 32'h0000_BEEF, 1'b0);
        check("sh_mis_lat", lat, 1);
        check("sh_mis_flag", {31'b0, mis}, 32'd1);
        check("sh_mis_oor", {31'b0, oor}, 32'd0);
        check("sh_mis_mem", reads + writes, 0);
        check("sh_mis_memval", mem[127], 32'hDAD5_B011);

        doOp(LW, 32'h1FE, 32'h0, 1'b0);
        check("lw_mis_flag", {31'b0, mis}, 32'd1);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_data", LoadData, 32'h0);

        doOp(SH, 32'h1FE, 32'h0000_BEEF, 1'b0);
        check("sh_lat", lat, 3);
        check("sh_wdata", wrData, 32'hBEEF_B011);
        check("sh_mis_clear", {31'b0, mis}, 32'd0);

        doOp(LW, 32'h1FC, 32'h0, 1'b1);
        check("hold_data", LoadData, 32'hBEEF_B011);
        check("hold_reads", reads, 1);
        check("hold_ready", readyDuring, 0);

        doOp(LW, 32'h200, 32'h0, 1'b0);
        check("oor_flag", {31'b0, oor}, 32'd1);
        check("oor_mis", {31'b0, mis}, 32'd0);
        check("oor_data", LoadData, 32'h0);
        check("oor_mem", reads + writes, 0);
        check("oor_lat", lat, 1);

        doOp(LH, 32'h1FE, 32'h0, 1'b0);
        doOp(LW, 32'h202, 32'h0, 1'b0);
        check("both_mis", {31'b0, mis}, 32'd1);
        check("both_oor", {31'b0, oor}, 32'd1);

        @(negedge Clk);
        Op = SW;
        ByteAddr = 32'h0;
        StoreData = 32'h1234_5678;
        Req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_wr_memwr", {31'b0, MemWrite}, 32'd1);
        check("rst_wr_ready", {31'b0, Ready}, 32'd0);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_async_memwr", {31'b0, MemWrite}, 32'd0);
        check("rst_async_ready", {31'b0, Ready}, 32'd1);
        check("rst_async_done", {31'b0, Done}, 32'd0);
        Req = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_mem0", mem[0], 32'hCAFE_F00D);

        doOp(LW, 32'h0, 32'h0, 1'b0);
        check("post_rst_lw", LoadData, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
